booth_mult_param: RTL and testbench
===================================

Name: booth_mult_param

Overview:
- Parametrised multi-cycle radix-2 Booth multiplier for the MIPS datapath; the MULT/MULTU unit feeding the HI/LO registers.
- Generalises the fixed 32-bit signed multiplier:
  - WIDTH parameter.
  - Signed/unsigned mode select.
  - Operand latching.
  - busy/done handshake.
  - Result registers that change only on completion.
- Control unit pulses start, waits for done, then writes high/low into HI/LO.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CW, 7, iteration-counter width; must satisfy 2^CW > WIDTH+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- X  input  WIDTH  multiplicand; sampled with start.
- Y  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse when result is valid.
- high  output  WIDTH  upper half of the 2*WIDTH-bit product.
- low  output  WIDTH  lower half of the 2*WIDTH-bit product.

Behaviour:
- Reset: rst=1 at a rising edge forces:
  - state to IDLE;
  - busy=0, done=0, high=0, low=0;
  - counter and internal accumulator cleared.
  - Reset applies in any state, including mid-RUN; a partial result is discarded and high/low read 0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k → go to RUN, count=0, busy=1.
  - RUN: one Booth step per edge; after the (WIDTH+1)-th step → go to DONE.
  - DONE: done=1 for exactly one cycle, then back to IDLE. start=1 sampled in DONE is accepted like IDLE (back-to-back ops: RUN, done deasserts).
- Operand extension at accept:
  - Operands extend to N=WIDTH+1 bits: sign-extend if signed_mode=1, zero-extend if 0.
  - Extended operands are latched internally; X, Y and signed_mode may change freely afterward.
- Booth step, always N iterations regardless of mode:
  - Accumulator A is N+1 bits; shift register Q holds the extended multiplier with a Q-1 bit.
  - Pair {Q[0],Q-1} = 10 → A -= M.
  - Pair 01 → A += M.
  - Pair 00 or 11 → no change.
  - Then arithmetic right shift of {A,Q,Q-1} by 1.
  - The multiplier bit pair comes from the shifting register, never by indexing the input bus with the counter.
- Result:
  - {high,low} = low 2*WIDTH bits of the 2N-bit product.
  - Exact for both modes: signed product fits in 2*WIDTH signed; unsigned product fits in 2*WIDTH unsigned.
- Latency:
  - busy=1 from edge k+1 through edge k+WIDTH+1.
  - done and the new high/low are registered at edge k+WIDTH+1, i.e. WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
- Output stability:
  - high/low hold the last completed result until the next completion or reset.
  - Intermediate accumulator values are never visible on high/low.
- start during RUN: ignored, with no effect on the operation in progress and no queuing.
- start held high continuously: a new operation is accepted every WIDTH+2 cycles (at each DONE); each produces exactly one done pulse.
- Simultaneous rst and start: rst wins; the block stays in IDLE.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=32, signed_mode=1, X=0xFFFFFFF9 (-7), Y=3, start one cycle → done exactly 33 edges after accept; high=0xFFFFFFFF, low=0xFFFFFFEB; busy high 33 cycles.
- WIDTH=32, signed_mode=0, X=Y=0xFFFFFFFF → high=0xFFFFFFFE, low=0x00000001. Same operands with signed_mode=1 → high=0, low=1.
- WIDTH=32, signed, X=Y=0x80000000 → high=0x40000000, low=0. Then X=0x7FFFFFFF, Y=0x80000000 → high=0xC0000000, low=0x80000000.
- start pulsed again at cycle 10 of RUN with different operands → ignored; result matches first operands only; single done pulse. Start asserted in the DONE cycle → second op accepted, second done 33 edges later.
- rst asserted at cycle 15 of RUN → next edge: busy=0, done=0, high=low=0, state IDLE. A following start computes correctly (5*6 → low=30, high=0).
- WIDTH=8 instance: signed 0x80×0x7F → high=0xC0, low=0x80; unsigned 0xFF×0x02 → high=0x01, low=0xFE; done 9 edges after accept.

Source files
------------

// File: rtl/booth_mult_param.sv
// ---------------------------------------------------------------------------
// booth_mult_param
//
// Multi-cycle radix-2 Booth multiplier. It serves as the MULT/MULTU unit that
// feeds the HI/LO registers of the MIPS datapath.
//
// The operands are extended to N = WIDTH+1 bits. The extension is a sign
// extension for signed mode and a zero extension for unsigned mode, so one
// signed Booth engine covers both instructions. The engine always runs N
// iterations. The low 2*WIDTH bits of the 2N-bit product are exact in both
// modes.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        request, only honoured in IDLE or DONE
//   signed_mode  1 = signed (MULT), 0 = unsigned (MULTU), sampled with start
//   X            multiplicand, sampled with start
//   Y            multiplier, sampled with start
//   busy         high while the Booth iterations run
//   done         one-cycle pulse when high/low carry a new result
//   high         upper WIDTH bits of the product
//   low          lower WIDTH bits of the product
// ---------------------------------------------------------------------------
module booth_mult_param #(
  parameter int WIDTH = 32,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low
);

  localparam int N = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Extend an operand to N bits according to the requested mode.
  function automatic logic [N-1:0] ext_op(input logic [WIDTH-1:0] v,
                                          input logic sgn);
    ext_op = {sgn & v[WIDTH-1], v};
  endfunction

  state_t           state_r, state_s;
  // Accumulator is one bit wider than the operands so that A +/- M never overflows.
  logic [N:0]       acc_r, acc_s;
  logic [N:0]       m_r, m_s;
  logic [N-1:0]     q_r, q_s;
  logic             qm1_r, qm1_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] high_r, high_s;
  logic [WIDTH-1:0] low_r, low_s;

  logic [N:0]       sum_s;
  logic [N:0]       acc_sh_s;
  logic [N-1:0]     q_sh_s;
  logic [N-1:0]     x_ext_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operand extension applied at accept time.
  always_comb begin
    x_ext_s = ext_op(X, signed_mode);
  end

  // One Booth step: add/subtract selected by {Q[0],Q-1}, then arithmetic shift right.
  always_comb begin
    sum_s = acc_r;
    case ({q_r[0], qm1_r})
      2'b10:   sum_s = acc_r - m_r;
      2'b01:   sum_s = acc_r + m_r;
      default: sum_s = acc_r;
    endcase
    acc_sh_s = {sum_s[N], sum_s[N:1]};
    q_sh_s   = {sum_s[0], q_r[N-1:1]};
    // The full product after the last step is {acc[N-1:0], q}. Only its low 2*WIDTH bits are kept.
    prod_s   = {acc_sh_s[WIDTH-2:0], q_sh_s};
  end

  // Next-state and next-datapath logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    m_s     = m_r;
    q_s     = q_r;
    qm1_s   = qm1_r;
    cnt_s   = cnt_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    high_s  = high_r;
    low_s   = low_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = RUN;
          busy_s  = 1'b1;
          acc_s   = {(N+1){1'b0}};
          m_s     = {x_ext_s[N-1], x_ext_s};
          q_s     = ext_op(Y, signed_mode);
          qm1_s   = 1'b0;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s = acc_sh_s;
        q_s   = q_sh_s;
        qm1_s = q_r[0];
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(N - 1)) begin
          // Last step: publish the result and pulse done on the same edge.
          state_s = DONE;
          done_s  = 1'b1;
          high_s  = prod_s[2*WIDTH-1:WIDTH];
          low_s   = prod_s[WIDTH-1:0];
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers. Reset also discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= {(N+1){1'b0}};
      m_r    <= {(N+1){1'b0}};
      q_r    <= {N{1'b0}};
      qm1_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      high_r <= {WIDTH{1'b0}};
      low_r  <= {WIDTH{1'b0}};
    end else begin
      acc_r  <= acc_s;
      m_r    <= m_s;
      q_r    <= q_s;
      qm1_r  <= qm1_s;
      cnt_r  <= cnt_s;
      busy_r <= busy_s;
      done_r <= done_s;
      high_r <= high_s;
      low_r  <= low_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign high = high_r;
  assign low  = low_r;

endmodule

// File: tb/tb_booth_mult_param.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_param
//
// Scoreboard bench for booth_mult_param. It uses a 32-bit instance and an
// 8-bit instance. Stimulus pushes the hand-computed product and the cycle at
// which done should appear. Monitors pop an entry on every done pulse. They
// compare the product, the latency and the number of busy cycles.
// ---------------------------------------------------------------------------
module tb_booth_mult_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] x32 = 32'h0, y32 = 32'h0;
  logic        busy32, done32;
  logic [31:0] high32, low32;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  x8 = 8'h0, y8 = 8'h0;
  logic        busy8, done8;
  logic [7:0]  high8, low8;

  booth_mult_param #(.WIDTH(32), .CW(7)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
    .X(x32), .Y(y32), .busy(busy32), .done(done32),
    .high(high32), .low(low32)
  );

  booth_mult_param #(.WIDTH(8), .CW(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .X(x8), .Y(y8), .busy(busy8), .done(done8),
    .high(high8), .low(low8)
  );

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   bcnt32 = 0;
  int   bcnt8 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_excl32", {63'd0, busy32 & done32}, 64'd0);
    if (done32) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk("prod32", {high32, low32}, e.prod);
        chk("latency32", 64'(cyc), 64'(e.cyc));
        chk("busy_cycles32", 64'(bcnt32), 64'd33);
      end
      bcnt32 = 0;
    end else if (busy32) begin
      bcnt32++;
    end
    if (rst) bcnt32 = 0;
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_excl8", {63'd0, busy8 & done8}, 64'd0);
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        chk("prod8", {48'd0, high8, low8}, e.prod);
        chk("latency8", 64'(cyc), 64'(e.cyc));
        chk("busy_cycles8", 64'(bcnt8), 64'd9);
      end
      bcnt8 = 0;
    end else if (busy8) begin
      bcnt8++;
    end
    if (rst) bcnt8 = 0;
  end

  // Pulse start for one cycle on the 32-bit unit, then scramble the operands.
  task automatic go32(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e, input bit push);
    exp_t t;
    @(posedge clk); #1;
    sm32 = s; x32 = a; y32 = b; start32 = 1'b1;
    t.prod = e; t.cyc = cyc + 34;
    if (push) q32.push_back(t);
    @(posedge clk); #1;
    start32 = 1'b0; x32 = 32'hDEADBEEF; y32 = 32'h12345678; sm32 = ~s;
  endtask

  // Pulse start for one cycle on the 8-bit unit, then scramble the operands.
  task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] e);
    exp_t t;
    @(posedge clk); #1;
    sm8 = s; x8 = a; y8 = b; start8 = 1'b1;
    t.prod = {48'd0, e}; t.cyc = cyc + 10;
    q8.push_back(t);
    @(posedge clk); #1;
    start8 = 1'b0; x8 = 8'hA5; y8 = 8'h3C; sm8 = ~s;
  endtask

  // Wait until both scoreboards are empty, bounded by a cycle budget.
  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      chk("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
      q32.delete();
      q8.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t t;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy32", {63'd0, busy32}, 64'd0);
    chk("rst_done32", {63'd0, done32}, 64'd0);
    chk("rst_prod32", {high32, low32}, 64'd0);
    chk("rst_prod8", {48'd0, high8, low8}, 64'd0);

    // -7 * 3 signed
    go32(1'b1, 32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFF_FFFFFFEB, 1'b1);
    drain();
    // 0xFFFFFFFF^2 unsigned, then signed (-1 * -1)
    go32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
    drain();
    go32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b1);
    drain();
    // Most-negative corner cases
    go32(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1);
    drain();
    go32(1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b1);
    drain();
    chk("hold32", {high32, low32}, 64'hC0000000_80000000);

    // A start during RUN must be ignored.
    go32(1'b0, 32'd1000, 32'd1000, 64'd1000000, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    sm32 = 1'b1; x32 = 32'd7; y32 = 32'd9; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    drain();

    // A start in the DONE cycle is accepted back-to-back.
    go32(1'b0, 32'd12, 32'd11, 64'd132, 1'b1);
    n = 0;
    while (!done32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen32", {63'd0, done32}, 64'd1);
    sm32 = 1'b1; x32 = 32'hFFFFFFFE; y32 = 32'd50; start32 = 1'b1;
    t.prod = 64'hFFFFFFFF_FFFFFF9C; t.cyc = cyc + 34;
    q32.push_back(t);
    @(posedge clk); #1;
    start32 = 1'b0;
    drain();

    // Reset mid-RUN discards the partial result.
    go32(1'b0, 32'd123456, 32'd654321, 64'd0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy32", {63'd0, busy32}, 64'd0);
    chk("midrst_done32", {63'd0, done32}, 64'd0);
    chk("midrst_prod32", {high32, low32}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done32", {high32, low32}, 64'd0);
    go32(1'b1, 32'd5, 32'd6, 64'd30, 1'b1);
    drain();

    // rst and start together: rst wins.
    rst = 1'b1; start32 = 1'b1; sm32 = 1'b1; x32 = 32'd3; y32 = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0; start32 = 1'b0;
    @(negedge clk);
    chk("rst_start_busy32", {63'd0, busy32}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // 8-bit instance
    go8(1'b1, 8'h80, 8'h7F, 16'hC080);
    drain();
    go8(1'b0, 8'hFF, 8'h02, 16'h01FE);
    drain();
    go8(1'b1, 8'hFD, 8'hFB, 16'h000F);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
